// File: rtl/mul_ctrl_pkg.sv
// Shared widths, funct codes and FSM state encoding for the mul_ctrl M-extension sequencer.
// Also provides the `GPR_WIDTH / `On / `Off defines used by the other mul_ctrl files.
`ifndef MUL_CTRL_DEFINES
`define MUL_CTRL_DEFINES
`define GPR_WIDTH 32
`define On  1'b1
`define Off 1'b0
`endif

package mul_ctrl_pkg;

    localparam logic [1:0] MUL_FN_MUL    = 2'b00;
    localparam logic [1:0] MUL_FN_MULH   = 2'b01;
    localparam logic [1:0] MUL_FN_MULHSU = 2'b10;
    localparam logic [1:0] MUL_FN_MULHU  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_FIX   = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // rs1 is treated as signed for MULH and MULHSU.
    function automatic logic fn_s1(input logic [1:0] fn);
        return (fn == MUL_FN_MULH) || (fn == MUL_FN_MULHSU);
    endfunction

    function automatic logic fn_s2(input logic [1:0] fn);
        return (fn == MUL_FN_MULH);
    endfunction

    // Signedness class; MUL and MULHU share class 00 because MUL's low half is sign-agnostic.
    function automatic logic [1:0] fn_class(input logic [1:0] fn);
        return {fn_s1(fn), fn_s2(fn)};
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement negate: used both to form operand magnitudes and to
// restore the sign of the unsigned product.
module mul_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing controller for the multi-cycle unsigned 32x32 multiplier (MUL/MULH/MULHSU/MULHU).
// Define MUL_FUSE_EN to reuse the last sign-corrected product for a matching request.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int XLEN     = `GPR_WIDTH,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        funct_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [4:0]        rd_i,
    input  logic              flush_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_data_o,
    output logic [4:0]        resp_rd_o,
    output logic              resp_err_o,
    output logic              mul_ce_o,
    output logic [XLEN-1:0]   mul_rs1_o,
    output logic [XLEN-1:0]   mul_rs2_o,
    input  logic [2*XLEN-1:0] mul_result_i,
    input  logic              mul_ready_i
);

    localparam int PW   = 2 * XLEN;
    localparam int WD_W = $clog2(MAX_WAIT + 1);

    state_e          state_q, state_d;
    logic [1:0]      funct_q, funct_d;
    logic [4:0]      rd_q, rd_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] mag1_q, mag1_d, mag2_q, mag2_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic [WD_W-1:0] wd_q, wd_d, wd_inc;

    logic [XLEN-1:0] mag1_c, mag2_c;
    logic [PW-1:0]   prod_fix;
    logic            neg_in, zero_in, accept, wd_timeout;

    function automatic logic [XLEN-1:0] pick_half(input logic [PW-1:0] p, input logic [1:0] fn);
        return (fn == MUL_FN_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
    endfunction

    mul_sign_fix #(.W(XLEN)) u_fix_rs1 (
        .val_i (rs1_i),
        .neg_i (fn_s1(funct_i) & rs1_i[XLEN-1]),
        .val_o (mag1_c)
    );

    mul_sign_fix #(.W(XLEN)) u_fix_rs2 (
        .val_i (rs2_i),
        .neg_i (fn_s2(funct_i) & rs2_i[XLEN-1]),
        .val_o (mag2_c)
    );

    mul_sign_fix #(.W(PW)) u_fix_prod (
        .val_i (prod_q),
        .neg_i (neg_q),
        .val_o (prod_fix)
    );

    assign neg_in     = (fn_s1(funct_i) & rs1_i[XLEN-1]) ^ (fn_s2(funct_i) & rs2_i[XLEN-1]);
    assign zero_in    = (rs1_i == '0) || (rs2_i == '0);
    assign accept     = (state_q == ST_IDLE) && req_valid_i && !flush_i;
    assign wd_inc     = wd_q + WD_W'(1);
    assign wd_timeout = (state_q == ST_BUSY) && !mul_ready_i && (wd_inc == WD_W'(MAX_WAIT));

`ifdef MUL_FUSE_EN
    logic            fuse_vld_q, fuse_vld_d;
    logic [XLEN-1:0] fuse_rs1_q, fuse_rs1_d, fuse_rs2_q, fuse_rs2_d;
    logic [1:0]      fuse_cls_q, fuse_cls_d;
    logic [PW-1:0]   fuse_prod_q, fuse_prod_d;
    logic [XLEN-1:0] op_rs1_q, op_rs1_d, op_rs2_q, op_rs2_d;
    logic            fuse_hit;

    assign fuse_hit = fuse_vld_q && (rs1_i == fuse_rs1_q) && (rs2_i == fuse_rs2_q)
                   && (fn_class(funct_i) == fuse_cls_q);

    always_comb begin
        fuse_vld_d  = fuse_vld_q;
        fuse_rs1_d  = fuse_rs1_q;
        fuse_rs2_d  = fuse_rs2_q;
        fuse_cls_d  = fuse_cls_q;
        fuse_prod_d = fuse_prod_q;
        op_rs1_d    = op_rs1_q;
        op_rs2_d    = op_rs2_q;
        if (accept) begin
            op_rs1_d = rs1_i;
            op_rs2_d = rs2_i;
        end
        if (state_q == ST_FIX) begin
            fuse_vld_d  = `On;
            fuse_rs1_d  = op_rs1_q;
            fuse_rs2_d  = op_rs2_q;
            fuse_cls_d  = fn_class(funct_q);
            fuse_prod_d = prod_fix;
        end
        // A flush anywhere (including one that kills the FIX write) or a timeout drops the entry.
        if (flush_i || wd_timeout) begin
            fuse_vld_d = `Off;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fuse_vld_q <= `Off;
        end else begin
            fuse_vld_q <= fuse_vld_d;
        end
        fuse_rs1_q  <= fuse_rs1_d;
        fuse_rs2_q  <= fuse_rs2_d;
        fuse_cls_q  <= fuse_cls_d;
        fuse_prod_q <= fuse_prod_d;
        op_rs1_q    <= op_rs1_d;
        op_rs2_q    <= op_rs2_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        funct_d = funct_q;
        rd_d    = rd_q;
        neg_d   = neg_q;
        mag1_d  = mag1_q;
        mag2_d  = mag2_q;
        prod_d  = prod_q;
        data_d  = data_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (accept) begin
                    funct_d = funct_i;
                    rd_d    = rd_i;
                    neg_d   = neg_in;
                    err_d   = `Off;
                    // The multiplier reads a zero operand as "not loaded", so zeros bypass it.
                    if (zero_in) begin
                        data_d  = '0;
                        state_d = ST_RESP;
                    end
`ifdef MUL_FUSE_EN
                    else if (fuse_hit) begin
                        data_d  = pick_half(fuse_prod_q, funct_i);
                        state_d = ST_RESP;
                    end
`endif
                    else begin
                        mag1_d  = mag1_c;
                        mag2_d  = mag2_c;
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                state_d = flush_i ? ST_IDLE : ST_BUSY;
            end
            ST_BUSY: begin
                wd_d = wd_inc;
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (mul_ready_i) begin
                    prod_d  = mul_result_i;
                    state_d = ST_FIX;
                end else if (wd_timeout) begin
                    err_d   = `On;
                    data_d  = '0;
                    state_d = ST_RESP;
                end
            end
            ST_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    data_d  = pick_half(prod_fix, funct_q);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush_i || resp_ready_i) begin
                    err_d   = `Off;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            funct_q <= MUL_FN_MUL;
            rd_q    <= '0;
            neg_q   <= `Off;
            mag1_q  <= '0;
            mag2_q  <= '0;
            prod_q  <= '0;
            data_q  <= '0;
            err_q   <= `Off;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            funct_q <= funct_d;
            rd_q    <= rd_d;
            neg_q   <= neg_d;
            mag1_q  <= mag1_d;
            mag2_q  <= mag2_d;
            prod_q  <= prod_d;
            data_q  <= data_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE) && !flush_i;
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_data_o  = data_q;
    assign resp_rd_o    = rd_q;
    assign resp_err_o   = err_q;
    // Enable drops in FIX/RESP/IDLE, so there is always a low cycle between operations.
    assign mul_ce_o     = (state_q == ST_START) || (state_q == ST_BUSY);
    assign mul_rs1_o    = mag1_q;
    assign mul_rs2_o    = mag2_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard testbench for mul_ctrl: a behavioural multiplier stub, a reference model of the
// RISC-V M-extension multiply results, and a monitor that pops expectations on each response.
module tb_mul_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  funct_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        resp_err_o;
    logic        mul_ce_o;
    logic [31:0] mul_rs1_o, mul_rs2_o;
    logic [63:0] mul_result_i;
    logic        mul_ready_i;

    mul_ctrl #(.XLEN(32), .MAX_WAIT(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .funct_i      (funct_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .rd_i         (rd_i),
        .flush_i      (flush_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_rd_o    (resp_rd_o),
        .resp_err_o   (resp_err_o),
        .mul_ce_o     (mul_ce_o),
        .mul_rs1_o    (mul_rs1_o),
        .mul_rs2_o    (mul_rs2_o),
        .mul_result_i (mul_result_i),
        .mul_ready_i  (mul_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   lat = 2;
    bit   stall = 1'b0;
    bit   hold = 1'b0;
    int   ce_rises = 0;
    int   ce_cycles = 0;

    // Reference-side view of the reuse entry (only consulted when the feature is built in).
    bit          fv = 1'b0;
    logic [31:0] fa, fb;
    logic [1:0]  fc;

    function automatic logic [1:0] cls_of(input logic [1:0] f);
        return {(f == 2'b01) || (f == 2'b10), f == 2'b01};
    endfunction

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = ((f == 2'b01) || (f == 2'b10)) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit push, input int l, input bit st);
        int   t = 0;
        bit   hit, nz;
        exp_t e;
        @(negedge clk_i);
        while (!req_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 200) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: req_ready_o=%b expected 1", req_ready_o);
        end
        lat   = l;
        stall = st;
        nz    = (a != 0) && (b != 0);
`ifdef MUL_FUSE_EN
        hit = fv && (fa == a) && (fb == b) && (fc == cls_of(f));
`else
        hit = 1'b0;
`endif
        e.rd   = rd;
        e.err  = nz && !hit && st;
        e.data = e.err ? 32'h0 : ref_mul(f, a, b);
        if (nz && !hit) begin
            if (st) fv = 1'b0;
            else begin
                fv = 1'b1; fa = a; fb = b; fc = cls_of(f);
            end
        end
        funct_i = f; rs1_i = a; rs2_i = b; rd_i = rd; req_valid_i = 1'b1;
        if (push) q.push_back(e);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (q.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic wait_valid(input bit level);
        int t = 0;
        @(negedge clk_i);
        while (resp_valid_o != level && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        if (resp_valid_o != level) begin
            nvec++;
            nerr++;
            $display("FAIL valid_timeout: resp_valid_o=%b expected %b", resp_valid_o, level);
        end
    endtask

    // Behavioural multiplier: raises ready lat cycles after enable, never while stalled.
    initial begin
        mul_ready_i  = 1'b0;
        mul_result_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mul_ce_o === 1'b1) begin
                ce_cycles++;
                if (ce_cycles == 1) ce_rises++;
                if (mul_rs1_o == 0 || mul_rs2_o == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL mul_zero_operand: rs1=%h rs2=%h expected both non-zero", mul_rs1_o, mul_rs2_o);
                end
                mul_ready_i  = !stall && (ce_cycles > lat);
                mul_result_i = {32'b0, mul_rs1_o} * {32'b0, mul_rs2_o};
            end else begin
                ce_cycles   = 0;
                mul_ready_i = 1'b0;
            end
        end
    end

    initial begin
        resp_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1 resp_ready_i = hold ? 1'b0 : ($urandom % 4 != 0);
        end
    end

    // Monitor: every accepted response is checked against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i === 1'b0 && resp_valid_o === 1'b1 && resp_ready_i === 1'b1) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL resp_unexpected: data=%h rd=%0d err=%b with no request pending",
                             resp_data_o, resp_rd_o, resp_err_o);
                end else begin
                    e = q.pop_front();
                    if ({resp_data_o, resp_rd_o, resp_err_o} !== e) begin
                        nerr++;
                        $display("FAIL resp: got data=%h rd=%0d err=%b expected data=%h rd=%0d err=%b",
                                 resp_data_o, resp_rd_o, resp_err_o, e.data, e.rd, e.err);
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        logic [31:0] a, b;
        rst_i = 1'b1; req_valid_i = 1'b0; funct_i = 2'b00; rs1_i = '0; rs2_i = '0;
        rd_i = '0; flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_state",
              {req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, resp_err_o, mul_ce_o, mul_rs1_o[15:0], mul_rs2_o[15:0]},
              {1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 16'h0, 16'h0});
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        send(2'b00, 32'd3, 32'hFFFF_FFFE, 5'd1, 1, 2, 0);
        send(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd2, 1, 1, 0);
        send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1, 3, 0);
        send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1, 2, 0);
        wait_drain();

        c0 = ce_rises;
        send(2'b01, 32'h0, 32'h1234, 5'd5, 1, 2, 0);
        wait_drain();
        check("zero_no_ce", 64'(ce_rises), 64'(c0));

        // Flush in the second BUSY cycle: no response and back in IDLE.
        send(2'b00, 32'h11, 32'h13, 5'd6, 0, 10, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        fv = 1'b0;
        @(negedge clk_i);
        check("flush_busy_idle", {61'b0, req_ready_o, mul_ce_o, resp_valid_o}, {61'b0, 1'b1, 1'b0, 1'b0});
        send(2'b00, 32'd7, 32'd6, 5'd7, 1, 1, 0);
        send(2'b00, 32'h1234, 32'h5678, 5'd8, 1, 2, 1);
        wait_drain();

        // Backpressure: response and tag held, no new request accepted.
        hold = 1'b1;
        send(2'b00, 32'd9, 32'd9, 5'd9, 1, 2, 0);
        wait_valid(1'b1);
        for (int i = 0; i < 5; i++) begin
            check("backpressure_hold", {26'b0, resp_valid_o, resp_data_o, resp_rd_o, req_ready_o},
                  {26'b0, 1'b1, 32'd81, 5'd9, 1'b0});
            @(negedge clk_i);
        end
        hold = 1'b0;
        wait_valid(1'b0);
        check("release_idle", 64'(req_ready_o), 64'd1);
        wait_drain();

        // Flush while the response is pending drops it.
        hold = 1'b1;
        send(2'b00, 32'd5, 32'd5, 5'd10, 0, 1, 0);
        wait_valid(1'b1);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        fv = 1'b0;
        @(negedge clk_i);
        check("flush_resp_drop", {62'b0, resp_valid_o, req_ready_o}, {62'b0, 1'b0, 1'b1});
        hold = 1'b0;

`ifdef MUL_FUSE_EN
        send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1, 2, 0);
        wait_drain();
        c0 = ce_rises;
        send(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1, 2, 0);
        wait_drain();
        check("fuse_no_ce", 64'(ce_rises), 64'(c0));
`endif

        for (int n = 0; n < 40; n++) begin
            case ($urandom % 6)
                0: a = 32'h0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom % 6)
                0: b = 32'h0;
                1: b = 32'h8000_0000;
                2: b = a;
                default: b = $urandom;
            endcase
            send(2'($urandom % 4), a, b, 5'($urandom % 32), 1, $urandom_range(1, 4), ($urandom % 10) == 0);
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
Sequencing controller for the multi-cycle unsigned 32x32 carry-save multiplier in the M-extension unit. Accepts MUL/MULH/MULHSU/MULHU requests from the execute stage over a valid/ready handshake. Converts signed operands to magnitudes, drives the multiplier's ce/operand/ready protocol, sign-corrects the 64-bit product, and returns the selected 32-bit half with the destination register tag.

Parameters:
XLEN, 32, operand width; equals `GPR_WIDTH; product is 2*XLEN.
MAX_WAIT, 8, BUSY-state watchdog limit in cycles before an error response.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  controller can accept a request this cycle
funct_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
rs1_i  in  XLEN  operand 1
rs2_i  in  XLEN  operand 2
rd_i  in  5  destination tag
flush_i  in  1  kill the in-flight operation (pipeline flush)
resp_valid_o  out  1  response valid
resp_ready_i  in  1  consumer accepts response
resp_data_o  out  XLEN  result
resp_rd_o  out  5  destination tag of response
resp_err_o  out  1  watchdog timeout; resp_data_o is 0
mul_ce_o  out  1  multiplier chip enable
mul_rs1_o  out  XLEN  magnitude of operand 1
mul_rs2_o  out  XLEN  magnitude of operand 2
mul_result_i  in  2*XLEN  unsigned product from the multiplier
mul_ready_i  in  1  multiplier ready/done

Behaviour:
- Reset (synchronous, rst_i=1 at clk_i edge): state=IDLE; req_ready_o=1; resp_valid_o=0; resp_data_o=0; resp_rd_o=0; resp_err_o=0; mul_ce_o=0; mul_rs1_o=0; mul_rs2_o=0; watchdog=0. Reset mid-operation abandons the op with no response.
- States: IDLE, START, BUSY, FIX, RESP.
- IDLE: req_ready_o=1. On req_valid_i, register funct, rd, and neg = (s1 & rs1[XLEN-1]) ^ (s2 & rs2[XLEN-1]).
  - s1=1 for MULH/MULHSU. s2=1 for MULH only. MUL uses the unsigned path; its low half is sign-agnostic.
  - Magnitude = two's-complement negate when the signed bit is set. 0x80000000 maps to 0x80000000 unsigned.
  - If either operand is 0: skip the multiplier, product=0, go to RESP (2-cycle latency). The multiplier's operand latch treats 0 as "not loaded", so zero operands must never reach it.
  - Otherwise go to START.
- START: one cycle with mul_ce_o=1 and magnitudes driven. mul_ready_i is ignored. Go to BUSY.
- BUSY: mul_ce_o=1 and operands held stable. Watchdog increments each cycle.
  - mul_ready_i=1: capture mul_result_i, go to FIX.
  - Watchdog reaches MAX_WAIT: resp_err_o=1, data=0, go to RESP.
- FIX: mul_ce_o=0. product = neg ? (~p + 1) : p, at 2*XLEN width. resp_data_o = product[XLEN-1:0] for MUL, else product[2*XLEN-1:XLEN]. Go to RESP.
- RESP: resp_valid_o=1; data, rd, and err held stable until resp_ready_i=1. Then go to IDLE and clear err.
  - No new request is accepted in the same cycle (req_ready_o=0 outside IDLE).
- flush_i: in START, BUSY, or FIX, return to IDLE next cycle with mul_ce_o=0 and no response.
  - In RESP, flush drops the pending response (resp_valid_o=0 next cycle).
  - flush_i in IDLE blocks acceptance that cycle.
- Flush and resp_ready_i in the same RESP cycle: the outcome is the same, go to IDLE.
- mul_ce_o is deasserted for at least one cycle between operations, so the multiplier status re-arms.

Optional Feature:
MUL_FUSE_EN
- Defined: keep the last signed-corrected 64-bit product plus its rs1, rs2, and signedness class.
  - A request whose operands and class match the stored entry goes IDLE->RESP (2-cycle latency) without touching the multiplier.
  - A MUL after a MULHU with equal operands also hits, because the low half is sign-agnostic.
  - The entry is invalidated on reset, flush, or error.
- Undefined: every non-zero request runs through the multiplier. There is no extra storage.

Decomposition:
- Shared defines header: `GPR_WIDTH, `On/`Off, funct codes (MUL_FN_MUL, MUL_FN_MULH, MUL_FN_MULHSU, MUL_FN_MULHU), state encodings.
- One natural sub-module, mul_sign_fix: combinational magnitude-in / negate-out helper, instantiated for operand conditioning and for product correction.

Test Plan:
- MUL rs1=3, rs2=0xFFFFFFFE -> resp_data=0xFFFFFFFA, rd echoed, err=0.
- MULH rs1=rs2=0x80000000 -> resp_data=0x40000000.
- MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU same operands -> 0xFFFFFFFF.
- MULH rs1=0, rs2=0x1234 -> 0 two cycles after acceptance, mul_ce_o never asserted.
- flush_i in the 2nd BUSY cycle -> no resp_valid_o, IDLE next cycle. A following MUL 7*6 -> 42. Hold mul_ready_i=0 for MAX_WAIT cycles -> resp_err_o=1, data=0.
- Backpressure: resp_ready_i=0 for 5 cycles -> resp_valid_o, data, and rd stable, req_ready_o=0. Release -> IDLE next cycle. With MUL_FUSE_EN, MULHU then MUL on 0xFFFFFFFF operands -> second result 0x00000001 with no mul_ce_o pulse.
